clock_rate_monitor: RTL and testbench
=====================================

CLOCK_RATE_MONITOR -- requirements
Module: clock_rate_monitor

Interface
REQ-001 SHALL have parameter DIV, default 4, the expected CLK cycles per slowCLK period (legal range 2..2^CNT_W-2).
REQ-002 SHALL have parameter TOL, default 0, the allowed absolute deviation in CLK cycles from DIV.
REQ-003 SHALL have parameter LOCK_COUNT, default 4, the number of consecutive in-tolerance periods required for lock.
REQ-004 SHALL have parameter CNT_W, default 16, the width of the period counter.
REQ-005 SHALL have port CLK, input, 1 bit: the single system clock, all logic clocked on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port slowCLK, input, 1 bit: the divided clock, asynchronous to this block and sampled as data.
REQ-008 SHALL have port clear, input, 1 bit: synchronous clear of sticky fault.
REQ-009 SHALL have port slow_rise, output, 1 bit: one-CLK pulse per detected slowCLK rising edge.
REQ-010 SHALL have port period, output, CNT_W bits: last measured period in CLK cycles.
REQ-011 SHALL have port period_valid, output, 1 bit: high once period holds a real measurement.
REQ-012 SHALL have port locked, output, 1 bit: high in state LOCKED.
REQ-013 SHALL have port fault, output, 1 bit: sticky error flag.

Function
REQ-014 SHALL pass slowCLK through a 2-flop synchronizer plus one history flop; rise = sync & ~hist; slow_rise asserts 3 CLK edges after the first edge sampling slowCLK high.
REQ-015 SHALL run counter cnt, set to 1 on slow_rise and incremented otherwise, saturating at 2^CNT_W-1; a steady divide-by-N input SHALL yield period = N.
REQ-016 SHALL, on each slow_rise except the first after SEARCH, load period <= cnt and set period_valid (held until reset).
REQ-017 SHALL define in-tolerance as DIV-TOL <= measured <= DIV+TOL, using unsigned CNT_W+1-bit arithmetic with no underflow.
REQ-018 SHALL implement states SEARCH, TRACK, LOCKED (2-bit encoding); reset state SEARCH.
REQ-019 SEARCH: first slow_rise -> TRACK with match_cnt=0, no period update.
REQ-020 TRACK: in-tolerance rise increments match_cnt; when it reaches LOCK_COUNT -> LOCKED; out-of-tolerance rise clears match_cnt and stays TRACK without setting fault.
REQ-021 LOCKED: out-of-tolerance rise -> TRACK, match_cnt=0, fault set.
REQ-022 Timeout: in TRACK or LOCKED, cnt exceeding 2*DIV+TOL with no rise -> SEARCH, match_cnt=0; sets fault only from LOCKED.
REQ-023 fault SHALL stay set until clear; a fault event in the same cycle as clear SHALL leave fault set.
REQ-024 A rise and timeout in the same cycle SHALL be treated as a rise (timeout ignored).

Reset
REQ-025 On rst_n low: synchronizer flops 0, cnt 0, period 0, period_valid 0, slow_rise 0, locked 0, fault 0, match_cnt 0, state SEARCH; asserted mid-measurement SHALL discard all history.
REQ-026 A slowCLK already high at reset release SHALL NOT produce slow_rise until a low-then-high is observed.

Configuration
REQ-027 Macro CLOCK_RATE_MONITOR_ERRCNT_EN defined: adds output err_count (8 bits, reset 0) counting every fault event, saturating at 255, cleared by clear (an event coincident with clear leaves count 1).
REQ-028 Macro undefined: no err_count port and no associated logic; all other behaviour identical.

Structure
REQ-029 State encoding typedef and default parameter constants SHALL live in shared package clock_monitor_pkg.
REQ-030 Synchronizer + edge detect SHALL be sub-module sync_edge_detect (ports CLK, rst_n, d, rise).

Verification
REQ-031 CLK period 20 ns, slowCLK = CLK/4, defaults -> locked rises after the 5th slow_rise (first seeds, 4 matches); period = 4.
REQ-032 Locked, then one slowCLK period stretched to 6 CLK -> fault=1, locked=0, state TRACK; relock after 4 more good periods, fault stays 1.
REQ-033 Locked, then slowCLK held constant -> SEARCH when cnt reaches 9 (2*DIV+1), fault=1, locked=0.
REQ-034 fault=1, assert clear for one cycle with no new fault -> fault=0; clear coincident with a new fault -> fault=1.
REQ-035 TOL=1, slowCLK alternating 3 and 5 CLK periods -> locks; a 6-CLK period -> fault.
REQ-036 rst_n pulsed low mid-TRACK with slowCLK high -> all outputs 0 immediately; no slow_rise until next low-to-high; with ERRCNT_EN, err_count returns to 0.

Source files
------------

// File: rtl/clock_monitor_pkg.sv
// Shared state encoding and default parameter values for the clock rate monitor.
package clock_monitor_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } mon_state_e;

    localparam int DEF_DIV        = 4;
    localparam int DEF_TOL        = 0;
    localparam int DEF_LOCK_COUNT = 4;
    localparam int DEF_CNT_W      = 16;

    // Saturating 8-bit increment used by the optional error counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer plus history flop producing a rising-edge strobe.
// The detector only arms after a synchronized low, so a level high at reset release is ignored.
module sync_edge_detect (
    input  logic CLK,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic       s1_q, s1_d;
    logic       s2_q, s2_d;
    logic       hist_q, hist_d;
    logic [1:0] prime_q, prime_d;
    logic       armed_q, armed_d;

    // Next-state for the synchronizer chain and arming logic.
    always_comb begin
        s1_d    = d;
        s2_d    = s1_q;
        hist_d  = s2_q;
        prime_d = {prime_q[0], 1'b1};
        // s2 only carries real samples once the chain has been refilled after reset
        if (prime_q[1] && !s2_q) begin
            armed_d = 1'b1;
        end else begin
            armed_d = armed_q;
        end
        rise = s2_q & ~hist_q & armed_q;
    end

    // Synchronizer, history and arming flops.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            hist_q  <= 1'b0;
            prime_q <= 2'b00;
            armed_q <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            hist_q  <= hist_d;
            prime_q <= prime_d;
            armed_q <= armed_d;
        end
    end

endmodule

// File: rtl/clock_rate_monitor.sv
// Measures slowCLK period in CLK cycles, tracks lock against DIV +/- TOL and flags faults.
// Optional build macro CLOCK_RATE_MONITOR_ERRCNT_EN adds an 8-bit saturating err_count output.
module clock_rate_monitor
    import clock_monitor_pkg::*;
#(
    parameter int DIV        = DEF_DIV,
    parameter int TOL        = DEF_TOL,
    parameter int LOCK_COUNT = DEF_LOCK_COUNT,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             slowCLK,
    input  logic             clear,
    output logic             slow_rise,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             fault
`ifdef CLOCK_RATE_MONITOR_ERRCNT_EN
    ,
    output logic [7:0]       err_count
`endif
);

    localparam int               MC_W    = $clog2(LOCK_COUNT + 1);
    localparam logic [MC_W-1:0]  LC_M    = MC_W'(LOCK_COUNT);
    localparam logic [CNT_W:0]   DIV_X   = (CNT_W + 1)'(DIV);
    localparam logic [CNT_W:0]   TOL_X   = (CNT_W + 1)'(TOL);
    localparam logic [CNT_W:0]   TMO_X   = (CNT_W + 1)'(2 * DIV + TOL);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             rise_s;
    logic             in_tol_s, timeout_s, fault_ev_s;
    logic [CNT_W:0]   cnt_x_s;
    mon_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             pvalid_q, pvalid_d;
    logic             slow_rise_q, slow_rise_d;
    logic             locked_q, locked_d;
    logic             fault_q, fault_d;
    logic [MC_W-1:0]  match_q, match_d;

    sync_edge_detect u_sync (
        .CLK   (CLK),
        .rst_n (rst_n),
        .d     (slowCLK),
        .rise  (rise_s)
    );

    // Period counter, lock state machine and sticky fault next-state.
    always_comb begin
        cnt_x_s     = {1'b0, cnt_q};
        in_tol_s    = ((cnt_x_s + TOL_X) >= DIV_X) && (cnt_x_s <= (DIV_X + TOL_X));
        timeout_s   = (cnt_x_s > TMO_X);
        state_d     = state_q;
        period_d    = period_q;
        pvalid_d    = pvalid_q;
        match_d     = match_q;
        fault_ev_s  = 1'b0;
        slow_rise_d = rise_s;
        if (rise_s) begin
            cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
        // A rise always takes priority over a timeout seen in the same cycle.
        case (state_q)
            ST_SEARCH: begin
                if (rise_s) begin
                    state_d = ST_TRACK;
                    match_d = {MC_W{1'b0}};
                end else begin
                    state_d = ST_SEARCH;
                end
            end
            ST_TRACK: begin
                if (rise_s) begin
                    period_d = cnt_q;
                    pvalid_d = 1'b1;
                    if (in_tol_s) begin
                        match_d = match_q + MC_W'(1);
                        if ((match_q + MC_W'(1)) == LC_M) begin
                            state_d = ST_LOCKED;
                        end else begin
                            state_d = ST_TRACK;
                        end
                    end else begin
                        match_d = {MC_W{1'b0}};
                    end
                end else if (timeout_s) begin
                    state_d = ST_SEARCH;
                    match_d = {MC_W{1'b0}};
                end else begin
                    state_d = ST_TRACK;
                end
            end
            ST_LOCKED: begin
                if (rise_s) begin
                    period_d = cnt_q;
                    pvalid_d = 1'b1;
                    if (!in_tol_s) begin
                        state_d    = ST_TRACK;
                        match_d    = {MC_W{1'b0}};
                        fault_ev_s = 1'b1;
                    end else begin
                        state_d = ST_LOCKED;
                    end
                end else if (timeout_s) begin
                    state_d    = ST_SEARCH;
                    match_d    = {MC_W{1'b0}};
                    fault_ev_s = 1'b1;
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                state_d = ST_SEARCH;
                match_d = {MC_W{1'b0}};
            end
        endcase
        if (fault_ev_s) begin
            fault_d = 1'b1;
        end else if (clear) begin
            fault_d = 1'b0;
        end else begin
            fault_d = fault_q;
        end
        locked_d = (state_d == ST_LOCKED);
    end

    // Monitor state and registered outputs.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_SEARCH;
            cnt_q       <= {CNT_W{1'b0}};
            period_q    <= {CNT_W{1'b0}};
            pvalid_q    <= 1'b0;
            slow_rise_q <= 1'b0;
            locked_q    <= 1'b0;
            fault_q     <= 1'b0;
            match_q     <= {MC_W{1'b0}};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            period_q    <= period_d;
            pvalid_q    <= pvalid_d;
            slow_rise_q <= slow_rise_d;
            locked_q    <= locked_d;
            fault_q     <= fault_d;
            match_q     <= match_d;
        end
    end

    assign slow_rise    = slow_rise_q;
    assign period       = period_q;
    assign period_valid = pvalid_q;
    assign locked       = locked_q;
    assign fault        = fault_q;

`ifdef CLOCK_RATE_MONITOR_ERRCNT_EN
    logic [7:0] err_q, err_d;

    // Fault event counter; an event coincident with clear restarts the count at one.
    always_comb begin
        if (fault_ev_s) begin
            err_d = clear ? 8'd1 : sat_inc8(err_q);
        end else if (clear) begin
            err_d = 8'd0;
        end else begin
            err_d = err_q;
        end
    end

    // Error counter register.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 8'd0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_count = err_q;
`endif

endmodule

// File: tb/tb_clock_rate_monitor.sv
// Scoreboard bench: two monitors (TOL=0 and TOL=1) share one slowCLK; a period-level model
// predicts the outputs at each detected rise and a negedge monitor compares them.
module tb_clock_rate_monitor;

    localparam int DIV = 4;
    localparam int LC  = 4;
    localparam int CW  = 16;

    typedef struct {
        int exp_cyc;
        int period;
        bit pv;
        bit lk;
        bit ft;
        int ec;
    } exp_t;

    logic          CLK = 1'b0;
    logic          rst_n, slowCLK, clear;
    logic [1:0]    slow_rise_a, pvalid_a, locked_a, fault_a;
    logic [CW-1:0] period_a [2];
    logic [7:0]    errc_a [2];

    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    int   prev_p = 0;
    exp_t q0[$];
    exp_t q1[$];

    int m_state [2];
    int m_match [2];
    int m_period [2];
    int m_pv [2];
    int m_fault [2];
    int m_err [2];

    clock_rate_monitor #(.DIV(DIV), .TOL(0), .LOCK_COUNT(LC), .CNT_W(CW)) dut0 (
        .CLK(CLK), .rst_n(rst_n), .slowCLK(slowCLK), .clear(clear),
        .slow_rise(slow_rise_a[0]), .period(period_a[0]), .period_valid(pvalid_a[0]),
        .locked(locked_a[0]), .fault(fault_a[0])
`ifdef CLOCK_RATE_MONITOR_ERRCNT_EN
        , .err_count(errc_a[0])
`endif
    );

    clock_rate_monitor #(.DIV(DIV), .TOL(1), .LOCK_COUNT(LC), .CNT_W(CW)) dut1 (
        .CLK(CLK), .rst_n(rst_n), .slowCLK(slowCLK), .clear(clear),
        .slow_rise(slow_rise_a[1]), .period(period_a[1]), .period_valid(pvalid_a[1]),
        .locked(locked_a[1]), .fault(fault_a[1])
`ifdef CLOCK_RATE_MONITOR_ERRCNT_EN
        , .err_count(errc_a[1])
`endif
    );

`ifndef CLOCK_RATE_MONITOR_ERRCNT_EN
    assign errc_a[0] = 8'd0;
    assign errc_a[1] = 8'd0;
`endif

    always #10 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_state[i] = 0; m_match[i] = 0; m_period[i] = 0;
            m_pv[i] = 0; m_fault[i] = 0; m_err[i] = 0;
        end
        prev_p = 0;
        q0.delete();
        q1.delete();
    endtask

    task automatic fault_event(input int i, input bit clr);
        m_fault[i] = 1;
        m_err[i]   = clr ? 1 : ((m_err[i] < 255) ? m_err[i] + 1 : 255);
    endtask

    // Abstract reference: state 0=search, 1=track, 2=locked; pprev is the period just ended.
    task automatic model_rise(input int i, input int pprev, input bit clr_mid, input bit clr_rise);
        int tol, thr;
        bit ev, intol;
        tol = (i == 0) ? 0 : 1;
        thr = 2 * DIV + tol;
        ev  = 0;
        if (m_state[i] != 0 && pprev >= thr + 2) begin
            if (m_state[i] == 2) fault_event(i, 1'b0);
            m_state[i] = 0;
            m_match[i] = 0;
        end
        if (clr_mid) begin
            m_fault[i] = 0;
            m_err[i]   = 0;
        end
        intol = (pprev >= DIV - tol) && (pprev <= DIV + tol);
        if (m_state[i] == 0) begin
            m_state[i] = 1;
            m_match[i] = 0;
        end else begin
            m_period[i] = pprev;
            m_pv[i]     = 1;
            if (m_state[i] == 1) begin
                if (intol) begin
                    m_match[i]++;
                    if (m_match[i] == LC) m_state[i] = 2;
                end else begin
                    m_match[i] = 0;
                end
            end else if (!intol) begin
                m_state[i] = 1;
                m_match[i] = 0;
                ev = 1;
            end
        end
        if (ev) fault_event(i, clr_rise);
        else if (clr_rise) begin
            m_fault[i] = 0;
            m_err[i]   = 0;
        end
    endtask

    task automatic push_exp(input int i);
        exp_t e;
        e.exp_cyc = cyc + 1;
        e.period  = m_period[i];
        e.pv      = (m_pv[i] != 0);
        e.lk      = (m_state[i] == 2);
        e.ft      = (m_fault[i] != 0);
        e.ec      = m_err[i];
        if (i == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic check_rise(input int i);
        exp_t e;
        if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_rise inst%0d: got slow_rise=1 at cycle %0d, required none", i, cyc);
        end else begin
            if (i == 0) e = q0.pop_front();
            else e = q1.pop_front();
            chk($sformatf("rise_cycle_i%0d", i), cyc, e.exp_cyc);
            chk($sformatf("period_i%0d", i), 32'(period_a[i]), e.period);
            chk($sformatf("period_valid_i%0d", i), 32'(pvalid_a[i]), 32'(e.pv));
            chk($sformatf("locked_i%0d", i), 32'(locked_a[i]), 32'(e.lk));
            chk($sformatf("fault_i%0d", i), 32'(fault_a[i]), 32'(e.ft));
`ifdef CLOCK_RATE_MONITOR_ERRCNT_EN
            chk($sformatf("err_count_i%0d", i), 32'(errc_a[i]), e.ec);
`endif
        end
    endtask

    // Monitor: every presented slow_rise pulse is matched against the scoreboard.
    always @(negedge CLK) begin
        if (rst_n === 1'b1) begin
            for (int i = 0; i < 2; i++) begin
                if (slow_rise_a[i] === 1'b1) check_rise(i);
            end
        end
    end

    task automatic check_all_zero();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_slow_rise_i%0d", i), 32'(slow_rise_a[i]), 32'd0);
            chk($sformatf("rst_period_i%0d", i), 32'(period_a[i]), 32'd0);
            chk($sformatf("rst_pvalid_i%0d", i), 32'(pvalid_a[i]), 32'd0);
            chk($sformatf("rst_locked_i%0d", i), 32'(locked_a[i]), 32'd0);
            chk($sformatf("rst_fault_i%0d", i), 32'(fault_a[i]), 32'd0);
`ifdef CLOCK_RATE_MONITOR_ERRCNT_EN
            chk($sformatf("rst_err_count_i%0d", i), 32'(errc_a[i]), 32'd0);
`endif
        end
    endtask

    task automatic do_reset(input bit hi);
        @(negedge CLK);
        slowCLK = hi;
        clear   = 1'b0;
        rst_n   = 1'b0;
        #1;
        check_all_zero();
        model_reset();
        repeat (2) @(negedge CLK);
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n, input bit lvl);
        repeat (n) begin
            @(negedge CLK);
            slowCLK = lvl;
            clear   = 1'b0;
        end
    endtask

    // One slowCLK period of p CLK cycles, high for h; the rise is handled at the edge after c==2.
    task automatic run_period(input int p, input int h, input bit clr_mid, input bit clr_rise,
                              input bit hold_chk);
        for (int c = 0; c < p; c++) begin
            @(negedge CLK);
            if (hold_chk) begin
                if (c == 11) chk("tmo_locked_before_i0", 32'(locked_a[0]), 32'd1);
                if (c == 12) begin
                    chk("tmo_locked_after_i0", 32'(locked_a[0]), 32'd0);
                    chk("tmo_fault_i0", 32'(fault_a[0]), 32'd1);
                    chk("tmo_locked_before_i1", 32'(locked_a[1]), 32'd1);
                end
                if (c == 13) begin
                    chk("tmo_locked_after_i1", 32'(locked_a[1]), 32'd0);
                    chk("tmo_fault_i1", 32'(fault_a[1]), 32'd1);
                end
            end
            slowCLK = (c < h);
            clear   = (c == 0 && clr_mid) || (c == 2 && clr_rise);
            if (c == 2) begin
                for (int i = 0; i < 2; i++) begin
                    model_rise(i, prev_p, clr_mid, clr_rise);
                    push_exp(i);
                end
            end
        end
        prev_p = p;
    endtask

    initial begin
        int p, h;
        bit cm, cr;
        rst_n   = 1'b0;
        slowCLK = 1'b0;
        clear   = 1'b0;
        model_reset();
        do_reset(1'b0);
        idle(4, 1'b0);
        repeat (8) run_period(4, 2, 0, 0, 0);
        // Stretched period while locked, then relock with fault held.
        run_period(6, 3, 0, 0, 0);
        repeat (6) run_period(4, 2, 0, 0, 0);
        run_period(4, 2, 1, 0, 0);
        run_period(4, 2, 0, 0, 0);
        // Clear coincident with a new fault keeps it set.
        run_period(6, 3, 0, 0, 0);
        run_period(4, 2, 0, 1, 0);
        repeat (6) run_period(4, 2, 0, 0, 0);
        // Held input while locked: timeout back to search.
        run_period(20, 2, 0, 0, 1);
        repeat (6) run_period(4, 2, 0, 0, 0);
        repeat (40) begin
            p  = ($urandom_range(0, 1) == 0) ? 4 : $urandom_range(3, 11);
            h  = $urandom_range(1, p - 1);
            cm = (prev_p <= 9) && ($urandom_range(0, 5) == 0);
            cr = ($urandom_range(0, 7) == 0);
            run_period(p, h, cm, cr, 0);
        end
        // Alternating 3/5 locks the TOL=1 monitor; a 6 then faults it.
        repeat (10) begin
            run_period(3, 1, 0, 0, 0);
            run_period(5, 2, 0, 0, 0);
        end
        run_period(6, 3, 0, 0, 0);
        run_period(4, 2, 0, 0, 0);
        // Reset mid-track with slowCLK high; no rise until a low-then-high.
        @(negedge CLK);
        slowCLK = 1'b1;
        do_reset(1'b1);
        idle(8, 1'b1);
        idle(4, 1'b0);
        repeat (6) run_period(4, 2, 0, 0, 0);
        idle(6, 1'b0);
        chk("scoreboard_drained", 32'(q0.size() + q1.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
